// File: rtl/sp_ram_arb_pkg.sv
// Shared definitions for the two-port arbiter in front of a single-port RAM:
// the ownership FSM state type and the port count.
package sp_ram_arb_pkg;

    localparam int NUM_PORTS = 2;

    // IDLE: nobody holds the lock; OWNx: port x holds the lock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM. A write has priority over a read in the same cycle.
// The read data is registered and is only refreshed by a read, so it holds
// the last value read. The array itself is never reset, so it maps onto
// block RAM.
module single_port_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_reg [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_reg;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_reg[addr] <= din;
        end
    end

    // Registered read port; keeps its value between reads and clears on reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            dout_reg <= '0;
        end else if (en && !we) begin
            dout_reg <= mem_reg[addr];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port arbiter in front of one single-port RAM.
// Idle arbitration is round-robin. A port can lock ownership for a burst.
// The burst is capped at BURST_MAX consecutive grants, but only when the
// other port is waiting.
// Optional feature: define SP_RAM_ARB_STATS_EN to add the per-port grant
// counters and the forced-release counter.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata
`ifdef SP_RAM_ARB_STATS_EN
    ,
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1,
    output logic [7:0]            force_rel_cnt
`endif
);

    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

    arb_state_t state_reg, state_next;
    logic [3:0] burst_cnt_reg, burst_cnt_next;
    logic       prio_reg, prio_next;      // port that wins an idle tie
    logic [1:0] gnt_int;
    logic       burst_at_max;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  rvalid_reg [NUM_PORTS];

    assign burst_at_max = (burst_cnt_reg >= BURST_MAX_C);

    // State register: owner, burst length and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            prio_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            prio_reg      <= prio_next;
        end
    end

    // Grant decode: the owner keeps priority unless its burst is exhausted
    // while the other port waits. An absent owner yields at once.
    always_comb begin
        gnt_int = 2'b00;
        if (!rst) begin
            case (state_reg)
                OWN0: begin
                    if (req[0] && !(burst_at_max && req[1])) gnt_int = 2'b01;
                    else if (req[1])                          gnt_int = 2'b10;
                end
                OWN1: begin
                    if (req[1] && !(burst_at_max && req[0])) gnt_int = 2'b10;
                    else if (req[0])                          gnt_int = 2'b01;
                end
                default: begin
                    if (req == 2'b11) gnt_int = prio_reg ? 2'b10 : 2'b01;
                    else              gnt_int = req;
                end
            endcase
        end
    end

    assign gnt = gnt_int;

    // Next state: a locking grantee becomes or stays the owner; otherwise idle.
    always_comb begin
        state_next     = IDLE;
        burst_cnt_next = '0;
        prio_next      = prio_reg;
        if (gnt_int[0]) begin
            prio_next = 1'b1;
            if (lock[0]) begin
                state_next     = OWN0;
                burst_cnt_next = (state_reg == OWN0) ?
                                 (burst_at_max ? burst_cnt_reg : burst_cnt_reg + 4'd1) : 4'd1;
            end
        end else if (gnt_int[1]) begin
            prio_next = 1'b0;
            if (lock[1]) begin
                state_next     = OWN1;
                burst_cnt_next = (state_reg == OWN1) ?
                                 (burst_at_max ? burst_cnt_reg : burst_cnt_reg + 4'd1) : 4'd1;
            end
        end
    end

    // The RAM command comes from the granted port. No grant means no access.
    assign ram_en   = |gnt_int;
    assign ram_we   = gnt_int[1] ? we[1]  : we[0];
    assign ram_addr = gnt_int[1] ? addr1  : addr0;
    assign ram_din  = gnt_int[1] ? din1   : din0;

    single_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .srst (rst),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rvalid
            // Read completion flag per port, one cycle after a granted read.
            always_ff @(posedge clk) begin
                if (rst) rvalid_reg[gi] <= 1'b0;
                else     rvalid_reg[gi] <= gnt_int[gi] & ~we[gi];
            end
            // A read granted just before reset must not complete into the reset cycle.
            assign rvalid[gi] = rvalid_reg[gi] & ~rst;
        end
    endgenerate

`ifdef SP_RAM_ARB_STATS_EN
    logic [15:0] gnt_cnt_reg [NUM_PORTS];
    logic [7:0]  force_rel_cnt_reg;
    logic        force_rel;

    assign force_rel = burst_at_max &&
                       (((state_reg == OWN0) && req[0] && req[1]) ||
                        ((state_reg == OWN1) && req[1] && req[0]));

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
            // Completed-grant counter; wraps naturally at 16 bits.
            always_ff @(posedge clk) begin
                if (rst)              gnt_cnt_reg[gi] <= '0;
                else if (gnt_int[gi]) gnt_cnt_reg[gi] <= gnt_cnt_reg[gi] + 16'd1;
            end
        end
    endgenerate

    // Forced-release counter; sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst)                                      force_rel_cnt_reg <= '0;
        else if (force_rel && force_rel_cnt_reg != 8'hFF) force_rel_cnt_reg <= force_rel_cnt_reg + 8'd1;
    end

    assign gnt_cnt0      = gnt_cnt_reg[0];
    assign gnt_cnt1      = gnt_cnt_reg[1];
    assign force_rel_cnt = force_rel_cnt_reg;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios, then randomized traffic.
// Every cycle is checked against a rule-level reference model.
module tb_sp_ram_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int BMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, lock, we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata;
`ifdef SP_RAM_ARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
    logic [7:0]    force_rel_cnt;
`endif

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BMAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .addr0  (addr0),
        .addr1  (addr1),
        .din0   (din0),
        .din1   (din1),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
`ifdef SP_RAM_ARB_STATS_EN
        ,
        .gnt_cnt0      (gnt_cnt0),
        .gnt_cnt1      (gnt_cnt1),
        .force_rel_cnt (force_rel_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model. It tracks who holds the lock, how many grants in a row
    // that port has received, who wins the next idle tie, the memory image
    // and the expected read pipeline.
    logic [DW-1:0] m_mem [16];
    int            m_owner, m_run, m_fav, m_last_g, m_frc;
    logic [1:0]    m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [15:0]   m_cnt [2];

    logic [1:0]    obs_gnt, obs_rvalid;
    logic [DW-1:0] obs_rdata;

    logic          p_req [2], p_we [2], p_lock [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_din [2];

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_fav = 0; m_last_g = -1; m_frc = 0;
        m_rvalid = 2'b00; m_rdata = '0; m_cnt[0] = '0; m_cnt[1] = '0;
    endtask

    function automatic logic [1:0] model_grant();
        int o, x;
        if (rst) return 2'b00;
        if (m_owner >= 0) begin
            o = m_owner; x = 1 - o;
            if (req[o]) begin
                if (m_run >= BMAX && req[x]) return 2'(1 << x);
                return 2'(1 << o);
            end
            if (req[x]) return 2'(1 << x);
            return 2'b00;
        end
        if (req == 2'b11) return 2'(1 << m_fav);
        return req;
    endfunction

    function automatic bit model_forced();
        int o;
        if (rst || m_owner < 0) return 1'b0;
        o = m_owner;
        return req[o] && req[1-o] && (m_run >= BMAX);
    endfunction

    task automatic model_update(input logic rst_v, input logic [1:0] eg);
        int g;
        logic [AW-1:0] a;
        if (rst_v) begin
            model_reset();
            return;
        end
        if (model_forced() && m_frc < 255) m_frc++;
        m_rvalid = 2'b00;
        if (eg == 2'b00) begin
            m_owner = -1; m_run = 0; m_last_g = -1;
            return;
        end
        g = eg[1] ? 1 : 0;
        m_cnt[g] = m_cnt[g] + 16'd1;
        m_fav = 1 - g;
        m_last_g = g;
        a = g ? addr1 : addr0;
        if (we[g]) m_mem[a] = g ? din1 : din0;
        else begin
            m_rvalid = 2'(1 << g);
            m_rdata  = m_mem[a];
        end
        if (lock[g]) begin
            m_run   = (m_owner == g) ? ((m_run < BMAX) ? m_run + 1 : m_run) : 1;
            m_owner = g;
        end else begin
            m_owner = -1; m_run = 0;
        end
    endtask

    // One clock cycle. Inputs are already driven. Outputs are sampled mid-cycle,
    // then the model advances at the edge.
    task automatic step(input logic rst_v);
        logic [1:0] eg;
        rst = rst_v;
        #4;
        eg = model_grant();
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata;
        check("gnt", gnt, eg);
        check("rvalid", rvalid, rst_v ? 2'b00 : m_rvalid);
        check("rdata", rdata, m_rdata);
`ifdef SP_RAM_ARB_STATS_EN
        check("gnt_cnt0", gnt_cnt0, m_cnt[0]);
        check("gnt_cnt1", gnt_cnt1, m_cnt[1]);
        check("force_rel_cnt", force_rel_cnt, m_frc);
`endif
        if (eg != 2'b00)
            $display("cyc=%0d port=%0d %s addr=%0h wdata=%0h lock=%0b", cyc, eg[1],
                     we[eg[1]] ? "WR" : "RD", eg[1] ? addr1 : addr0,
                     eg[1] ? din1 : din0, lock[eg[1]]);
        @(posedge clk);
        model_update(rst_v, eg);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; lock = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
    endtask

    // A pending ungranted request is held stable. Otherwise a fresh one may be issued.
    task automatic drive_random();
        for (int p = 0; p < 2; p++) begin
            if (!(p_req[p] && m_last_g != p)) begin
                p_req[p]  = ($urandom_range(0, 9) < 7);
                p_we[p]   = $urandom_range(0, 1) == 1;
                p_addr[p] = AW'($urandom);
                p_din[p]  = DW'($urandom);
            end
            p_lock[p] = ($urandom_range(0, 9) < 6);
        end
        req   = {p_req[1], p_req[0]};
        we    = {p_we[1], p_we[0]};
        lock  = {p_lock[1], p_lock[0]};
        addr0 = p_addr[0]; addr1 = p_addr[1];
        din0  = p_din[0];  din1  = p_din[1];
    endtask

    logic [1:0] exp34 [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int p = 0; p < 2; p++) p_req[p] = 1'b0;

        // Give every word a known value.
        for (int a = 0; a < 16; a++) begin
            req = 2'b01; we = 2'b01; addr0 = AW'(a); din0 = DW'($urandom);
            step(1'b0);
        end

        // Simultaneous reads of address 3 after reset.
        idle_inputs(); step(1'b1);
        req = 2'b11; addr0 = 4'd3; addr1 = 4'd3;
        step(1'b0); check("d32_gnt_first", obs_gnt, 2'b01);
        req = 2'b10;
        step(1'b0); check("d32_gnt_second", obs_gnt, 2'b10);
        check("d32_rvalid_first", obs_rvalid, 2'b01); check("d32_rdata_first", obs_rdata, m_mem[3]);
        req = 2'b00;
        step(1'b0); check("d32_rvalid_second", obs_rvalid, 2'b10); check("d32_rdata_second", obs_rdata, m_mem[3]);

        // Write on port 0, read it back on port 1.
        idle_inputs(); step(1'b1);
        req = 2'b01; we = 2'b01; addr0 = 4'd5; din0 = 8'hA5;
        step(1'b0);
        req = 2'b10; we = 2'b00; addr1 = 4'd5;
        step(1'b0); check("d33_gnt", obs_gnt, 2'b10); check("d33_no_rvalid_after_wr", obs_rvalid, 2'b00);
        req = 2'b00;
        step(1'b0); check("d33_rvalid", obs_rvalid, 2'b10); check("d33_rdata", obs_rdata, 8'hA5);

        // Locked burst against a competing requester.
        idle_inputs(); step(1'b1);
        exp34 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        req = 2'b11; lock = 2'b01; addr0 = 4'd1; addr1 = 4'd2;
        for (int i = 0; i < 6; i++) begin
            step(1'b0); check($sformatf("d34_gnt_%0d", i), obs_gnt, exp34[i]);
        end

        // Uncontested lock keeps its grant.
        idle_inputs(); step(1'b1);
        req = 2'b01; lock = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step(1'b0); check($sformatf("d35_gnt_%0d", i), obs_gnt, 2'b01);
        end
`ifdef SP_RAM_ARB_STATS_EN
        check("d35_force_rel", force_rel_cnt, 8'd0);
`endif

        // Reset in the third cycle of a port-1 locked read burst.
        idle_inputs(); step(1'b1);
        req = 2'b10; lock = 2'b10; addr1 = 4'd7;
        step(1'b0); step(1'b0);
        step(1'b1); check("d36_gnt_in_rst", obs_gnt, 2'b00); check("d36_rvalid_in_rst", obs_rvalid, 2'b00);
        req = 2'b11; lock = 2'b00;
        step(1'b0); check("d36_gnt_after", obs_gnt, 2'b01); check("d36_rvalid_after", obs_rvalid, 2'b00);

`ifdef SP_RAM_ARB_STATS_EN
        idle_inputs(); step(1'b1);
        req = 2'b01; repeat (3) step(1'b0);
        req = 2'b10; repeat (2) step(1'b0);
        req = 2'b00; step(1'b0);
        check("d37_cnt0", gnt_cnt0, 16'd3);
        check("d37_cnt1", gnt_cnt1, 16'd2);
        check("d37_frc", force_rel_cnt, 8'd0);
`endif

        // Randomized traffic with occasional resets.
        idle_inputs(); step(1'b1);
        for (int p = 0; p < 2; p++) p_req[p] = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            step($urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width; depth 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive locked grants to one port; legal range 1..15.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req[1:0]  input  2  per-port access request.
REQ-008 lock[1:0]  input  2  per-port request to keep ownership next cycle; ignored unless req of same port is high.
REQ-009 we[1:0]  input  2  per-port write enable; 1 means write, 0 means read.
REQ-010 addr0, addr1  input  ADDR_WIDTH each  per-port address.
REQ-011 din0, din1  input  DATA_WIDTH each  per-port write data.
REQ-012 gnt[1:0]  output  2  combinational grant, one-hot or zero; access occurs at the clk edge ending a granted cycle.
REQ-013 rvalid[1:0]  output  2  registered read-data-valid per port.
REQ-014 rdata  output  DATA_WIDTH  read data shared by both ports, qualified by rvalid.

Function
REQ-015 At most one gnt bit is high in any cycle; gnt[i] is high only when req[i] is high; gnt is 0 while rst is high.
REQ-016 FSM states: IDLE (no owner), OWN0, OWN1; the owner state means that port holds the lock.
REQ-017 In IDLE, a single requester is granted; with both requesting, the port not granted most recently wins (round-robin); port 0 wins after reset.
REQ-018 Granted port i with req[i]&lock[i] transitions to OWNi and its burst counter increments; if not locking, the FSM returns to or stays in IDLE.
REQ-019 In OWNi, port i is granted if req[i] is high; if req[i] is low, ownership drops to IDLE and the other port may be granted in that same cycle.
REQ-020 Burst counter counts consecutive grants to the owner; when it reaches BURST_MAX while the other port requests, the owner loses the grant for the next cycle (forced release to IDLE, other port wins); with no competing request, the owner keeps the lock and the counter saturates at BURST_MAX.
REQ-021 A granted write stores dinX at addrX at the edge ending the grant cycle; rvalid for that port stays 0 on the next cycle.
REQ-022 A granted read produces rvalid[i]=1 exactly one cycle later with rdata = mem[addrX]; read latency is 1 cycle and fully pipelined (back-to-back reads on consecutive cycles are allowed).
REQ-023 rdata holds its last read value when no read completes; rvalid bits are single-cycle pulses.
REQ-024 Read and write of the same address on consecutive cycles return the newly written data (no stale read).
REQ-025 Ungranted requests are not dropped silently: the requester holds req/we/addr/din stable until it sees gnt.

Reset
REQ-026 On rst: state=IDLE, round-robin pointer favours port 0, burst counter=0, rvalid=2'b00, rdata=0, statistics counters=0; RAM contents are not cleared.
REQ-027 Reset asserted mid-burst aborts ownership; no access is performed in any cycle where rst is high, and a read granted in the cycle before rst produces no rvalid.

Configuration
REQ-028 Macro SP_RAM_ARB_STATS_EN defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each), counting completed grants per port and wrapping at 16'hFFFF->0, plus output force_rel_cnt (8 bits, saturating) counting forced releases.
REQ-029 Macro undefined: those ports and their counters do not exist; all other behaviour is identical.

Structure
REQ-030 Shared package sp_ram_arb_pkg holds the FSM state enum (IDLE, OWN0, OWN1) and the constant NUM_PORTS=2.
REQ-031 Storage is one instance of the team's single_port_ram sub-module (write takes priority and output is registered on reads); the arbiter muxes we/addr/din into it and demuxes rvalid.

Verification
REQ-032 Reset then both ports read addr 3 in the same cycle -> gnt=01, then gnt=10 next cycle; rvalid=01 then 10, rdata=mem[3] both times.
REQ-033 Port0 writes 8'hA5 to addr 5; next cycle port1 reads addr 5 -> rvalid[1]=1 with rdata=8'hA5 one cycle after the port1 grant.
REQ-034 Port0 req+lock held for 6 cycles while port1 requests continuously, BURST_MAX=4 -> gnt=01 for 4 cycles, gnt=10 for 1 cycle, then port0 regranted.
REQ-035 Port0 locked without competition for 10 cycles -> gnt=01 all 10 cycles, no forced release.
REQ-036 rst asserted during the third cycle of a port1 locked burst of reads -> gnt=00 and rvalid=00 on the following cycle; after rst deasserts, both requesting -> port0 granted first.
REQ-037 With SP_RAM_ARB_STATS_EN defined, 3 port0 grants and 2 port1 grants -> gnt_cnt0=3, gnt_cnt1=2, force_rel_cnt=0.
